sprite_pos_ctrl: RTL and testbench



---
 rtl/sprite_pos_ctrl.sv | 106 ++++++++++
 tb/tb_sprite_pos_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pos_ctrl.sv
// sprite_pos_ctrl: debounced, tick-rate-limited, bounds-checked sprite origin from four pushbuttons.
// Define SPRITE_POS_WRAP_EN to wrap toroidally at the screen edges instead of clamping.
module sprite_pos_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SPRITE_W        = 64,
  parameter int SPRITE_H        = 64,
  parameter int X_INIT          = 288,
  parameter int Y_INIT          = 208,
  parameter int STEP            = 2,
  parameter int TICK_DIV        = 1000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        in_clk,
  input  logic        rst_n,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic [3:0]  btn_db,
  output logic        move_tick
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic signed [11:0] S  = 12'(STEP);
  localparam logic signed [11:0] XM = 12'(H_ACTIVE - SPRITE_W);
  localparam logic signed [11:0] YM = 12'(V_ACTIVE - SPRITE_H);

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  state_t          r_state;
  logic [3:0]      r_sync1, r_sync2, r_btn_db, r_btn_s;
  logic [DW-1:0]   r_db_cnt [4];
  logic [TW-1:0]   r_tick_cnt;
  logic [10:0]     r_x, r_y;
  logic            r_move;
  logic            w_tick, w_move;
  logic [10:0]     w_x_nx, w_y_nx;

  function automatic logic [10:0] step_axis(input logic [10:0] p, input logic dec, input logic inc,
                                            input logic signed [11:0] mx);
    logic signed [11:0] v;
    v = $signed({1'b0, p}) + ((inc & ~dec) ? S : (dec & ~inc) ? -S : 12'sd0);
`ifdef SPRITE_POS_WRAP_EN
    v = (v < 12'sd0) ? v + mx + 12'sd1 : (v > mx) ? v - mx - 12'sd1 : v;
`else
    v = (v < 12'sd0) ? 12'sd0 : (v > mx) ? mx : v;
`endif
    return v[10:0];
  endfunction

  assign w_tick = r_tick_cnt == TW'(TICK_DIV - 1);
  assign w_x_nx = step_axis(r_x, r_btn_s[1], r_btn_s[0], XM);
  assign w_y_nx = step_axis(r_y, r_btn_s[3], r_btn_s[2], YM);
`ifdef SPRITE_POS_WRAP_EN
  assign w_move = (r_btn_s[3] ^ r_btn_s[2]) | (r_btn_s[1] ^ r_btn_s[0]);
`else
  assign w_move = (w_x_nx != r_x) | (w_y_nx != r_y);
`endif

  // Movement uses the button snapshot taken on the tick cycle, not the live debounced value.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_btn_db   <= '0;
      r_btn_s    <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      r_tick_cnt <= '0;
      r_x        <= 11'(X_INIT);
      r_y        <= 11'(Y_INIT);
      r_move     <= 1'b0;
    end else begin
      r_sync1    <= {up, down, left, right};
      r_sync2    <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_btn_db[i]) r_db_cnt[i] <= '0;
        else if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_btn_db[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
      end
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_move     <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_tick) begin
          r_state <= S_UPDATE;
          r_btn_s <= r_btn_db;
        end
      end else begin
        r_x     <= w_x_nx;
        r_y     <= w_y_nx;
        r_move  <= w_move;
        r_state <= S_IDLE;
      end
    end
  end

  assign x_pos     = r_x;
  assign y_pos     = r_y;
  assign btn_db    = r_btn_db;
  assign move_tick = r_move;
endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// tb_sprite_pos_ctrl: directed checks of debounce, motion, bounds and async reset with small divisors.
module tb_sprite_pos_ctrl;
  logic        in_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [10:0] x_pos, y_pos;
  logic [3:0]  btn_db;
  logic        move_tick;
  int          total = 0;
  int          bad   = 0;

  sprite_pos_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .in_clk(in_clk), .rst_n(rst_n), .up(up), .down(down), .left(left), .right(right),
    .x_pos(x_pos), .y_pos(y_pos), .btn_db(btn_db), .move_tick(move_tick)
  );

  always #5 in_clk = ~in_clk;

  task automatic step;
    @(posedge in_clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) step;
    total += 4;
    if (x_pos !== 11'd288) begin bad++; $display("FAIL rst_hold_x got %0d want 288", x_pos); end
    if (y_pos !== 11'd208) begin bad++; $display("FAIL rst_hold_y got %0d want 208", y_pos); end
    if (btn_db !== 4'b0) begin bad++; $display("FAIL rst_hold_btn got %b want 0000", btn_db); end
    if (move_tick !== 1'b0) begin bad++; $display("FAIL rst_hold_tick got %b want 0", move_tick); end
    rst_n = 1'b1;
    repeat (3) step;
    total += 4;
    if (x_pos !== 11'd288) begin bad++; $display("FAIL rst_x got %0d want 288", x_pos); end
    if (y_pos !== 11'd208) begin bad++; $display("FAIL rst_y got %0d want 208", y_pos); end
    if (btn_db !== 4'b0) begin bad++; $display("FAIL rst_btn got %b want 0000", btn_db); end
    if (move_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got %b want 0", move_tick); end
  endtask

  task automatic test_glitch;
    logic seen = 1'b0;
    right = 1'b1;
    repeat (2) step;
    right = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step;
      if (btn_db !== 4'b0 || move_tick !== 1'b0) seen = 1'b1;
    end
    total += 2;
    if (seen) begin bad++; $display("FAIL glitch_btn got activity want none"); end
    if (x_pos !== 11'd288) begin bad++; $display("FAIL glitch_x got %0d want 288", x_pos); end
  endtask

  task automatic test_debounce;
    right = 1'b1;
    repeat (4) step;
    total++;
    if (btn_db !== 4'b0000) begin bad++; $display("FAIL db_early got %b want 0000", btn_db); end
    step;
    total++;
    if (btn_db !== 4'b0001) begin bad++; $display("FAIL db_accept got %b want 0001", btn_db); end
  endtask

  task automatic test_motion;
    int n;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (move_tick !== 1'b1 && n < 20) begin step; n++; end
      total += 2;
      if (move_tick !== 1'b1) begin bad++; $display("FAIL motion_timeout tick %0d got no pulse want pulse", k); end
      if (x_pos !== 11'(290 + 2 * k)) begin bad++; $display("FAIL motion_x tick %0d got %0d want %0d", k, x_pos, 290 + 2 * k); end
      step;
    end
    total++;
    if (y_pos !== 11'd208) begin bad++; $display("FAIL motion_y got %0d want 208", y_pos); end
    right = 1'b0;
    n = 0;
    while (btn_db !== 4'b0 && n < 20) begin step; n++; end
    total++;
    if (btn_db !== 4'b0) begin bad++; $display("FAIL motion_release got %b want 0000", btn_db); end
  endtask

  task automatic test_hold_both;
    int n = 0;
    logic seen = 1'b0;
    up = 1'b1;
    down = 1'b1;
    while (btn_db !== 4'b1100 && n < 20) begin step; n++; end
    total++;
    if (btn_db !== 4'b1100) begin bad++; $display("FAIL both_btn got %b want 1100", btn_db); end
    for (int k = 0; k < 24; k++) begin
      step;
      if (move_tick !== 1'b0) seen = 1'b1;
    end
    total += 2;
    if (y_pos !== 11'd208) begin bad++; $display("FAIL both_y got %0d want 208", y_pos); end
    if (seen) begin bad++; $display("FAIL both_tick got pulse want none"); end
    up = 1'b0;
    down = 1'b0;
    repeat (10) step;
  endtask

`ifndef SPRITE_POS_WRAP_EN
  task automatic test_clamp;
    int n = 0;
    logic seen = 1'b0;
    left = 1'b1;
    while (x_pos !== 11'd0 && n < 1500) begin step; n++; end
    total++;
    if (x_pos !== 11'd0) begin bad++; $display("FAIL clamp_lo_reach got %0d want 0", x_pos); end
    step;
    for (int k = 0; k < 16; k++) begin
      step;
      if (move_tick !== 1'b0) seen = 1'b1;
    end
    total += 2;
    if (x_pos !== 11'd0) begin bad++; $display("FAIL clamp_lo_x got %0d want 0", x_pos); end
    if (seen) begin bad++; $display("FAIL clamp_lo_tick got pulse want none"); end
    left = 1'b0;
    right = 1'b1;
    n = 0;
    seen = 1'b0;
    while (x_pos < 11'd576 && n < 3000) begin step; n++; end
    total++;
    if (x_pos !== 11'd576) begin bad++; $display("FAIL clamp_hi_reach got %0d want 576", x_pos); end
    step;
    for (int k = 0; k < 16; k++) begin
      step;
      if (move_tick !== 1'b0) seen = 1'b1;
    end
    total += 2;
    if (x_pos !== 11'd576) begin bad++; $display("FAIL clamp_hi_x got %0d want 576", x_pos); end
    if (seen) begin bad++; $display("FAIL clamp_hi_tick got pulse want none"); end
  endtask
`else
  task automatic test_wrap;
    int n = 0;
    left = 1'b1;
    while (x_pos !== 11'd0 && n < 1500) begin step; n++; end
    total++;
    if (x_pos !== 11'd0) begin bad++; $display("FAIL wrap_x_reach got %0d want 0", x_pos); end
    step;
    n = 0;
    while (move_tick !== 1'b1 && n < 20) begin step; n++; end
    total++;
    if (x_pos !== 11'd575) begin bad++; $display("FAIL wrap_x got %0d want 575", x_pos); end
    left = 1'b0;
    repeat (10) step;
    down = 1'b1;
    n = 0;
    while (y_pos !== 11'd416 && n < 1500) begin step; n++; end
    total++;
    if (y_pos !== 11'd416) begin bad++; $display("FAIL wrap_y_reach got %0d want 416", y_pos); end
    step;
    n = 0;
    while (move_tick !== 1'b1 && n < 20) begin step; n++; end
    total++;
    if (y_pos !== 11'd1) begin bad++; $display("FAIL wrap_y got %0d want 1", y_pos); end
    down = 1'b0;
    right = 1'b1;
    repeat (10) step;
  endtask
`endif

  task automatic test_async_reset;
    int n = 0;
    right = 1'b0;
    left = 1'b1;
    while (move_tick !== 1'b1 && n < 40) begin step; n++; end
    total++;
    if (move_tick !== 1'b1) begin bad++; $display("FAIL ar_pulse got none want pulse"); end
    repeat (3) step;
    rst_n = 1'b0;
    left = 1'b0;
    #1;
    total += 4;
    if (x_pos !== 11'd288) begin bad++; $display("FAIL ar_x got %0d want 288", x_pos); end
    if (y_pos !== 11'd208) begin bad++; $display("FAIL ar_y got %0d want 208", y_pos); end
    if (btn_db !== 4'b0) begin bad++; $display("FAIL ar_btn got %b want 0000", btn_db); end
    if (move_tick !== 1'b0) begin bad++; $display("FAIL ar_tick got %b want 0", move_tick); end
    repeat (2) step;
    rst_n = 1'b1;
    repeat (2) step;
    total += 2;
    if (x_pos !== 11'd288) begin bad++; $display("FAIL ar_after_x got %0d want 288", x_pos); end
    if (move_tick !== 1'b0) begin bad++; $display("FAIL ar_after_tick got %b want 0", move_tick); end
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_debounce;
    test_motion;
    test_hold_both;
`ifndef SPRITE_POS_WRAP_EN
    test_clamp;
`else
    test_wrap;
`endif
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
